// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded control and operands each cycle, with
// freeze (hold), flush (bubble) and a saturating count of inserted bubbles.
module id_ex_stage_reg #(
  parameter int WORD_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  wb_en_in,
  input  logic                  b_in,
  input  logic                  s_in,
  input  logic [3:0]            exe_cmd_in,
  input  logic [WORD_W-1:0]     pc_in,
  input  logic [WORD_W-1:0]     val_rn_in,
  input  logic [WORD_W-1:0]     val_rm_in,
  input  logic                  imm_in,
  input  logic [11:0]           shift_operand_in,
  input  logic [23:0]           signed_imm_24_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [REG_ADDR_W-1:0] src1_in,
  input  logic [REG_ADDR_W-1:0] src2_in,
  input  logic [3:0]            sr_in,
  output logic                  valid_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic                  wb_en_out,
  output logic                  b_out,
  output logic                  s_out,
  output logic [3:0]            exe_cmd_out,
  output logic [WORD_W-1:0]     pc_out,
  output logic [WORD_W-1:0]     val_rn_out,
  output logic [WORD_W-1:0]     val_rm_out,
  output logic                  imm_out,
  output logic [11:0]           shift_operand_out,
  output logic [23:0]           signed_imm_24_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic [REG_ADDR_W-1:0] src1_out,
  output logic [REG_ADDR_W-1:0] src2_out,
  output logic [3:0]            sr_out,
  output logic [CNT_W-1:0]      bubble_cnt
);

  localparam int CTRL_W = 6;

  logic hold;
  logic load_bubble;
  logic load_instr;

  // flush beats freeze; an unfrozen empty decode slot also becomes a bubble
  assign hold        = freeze & ~flush;
  assign load_bubble = flush | (~freeze & ~valid_in);
  assign load_instr  = ~freeze & ~flush & valid_in;

  logic [CTRL_W-1:0]     ctrl_in;
  logic [CTRL_W-1:0]     ctrl_next;
  logic [CTRL_W-1:0]     ctrl_reg;
  logic [3:0]            exe_cmd_clean;
  logic [3:0]            exe_cmd_next;
  logic [3:0]            exe_cmd_reg;
  logic [WORD_W-1:0]     pc_next, pc_reg;
  logic [WORD_W-1:0]     val_rn_next, val_rn_reg;
  logic [WORD_W-1:0]     val_rm_next, val_rm_reg;
  logic                  imm_next, imm_reg;
  logic [11:0]           shift_operand_next, shift_operand_reg;
  logic [23:0]           signed_imm_24_next, signed_imm_24_reg;
  logic [REG_ADDR_W-1:0] dest_next, dest_reg;
  logic [REG_ADDR_W-1:0] src1_next, src1_reg;
  logic [REG_ADDR_W-1:0] src2_next, src2_reg;
  logic [3:0]            sr_next, sr_reg;
  logic [CNT_W-1:0]      bubble_cnt_next, bubble_cnt_reg;

  assign ctrl_in = {valid_in, mem_read_in, mem_write_in, wb_en_in, b_in, s_in};

  // Control bits are only ever set by a real instruction, so a bubble is always inert
  generate
    for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl
      assign ctrl_next[gi] = load_instr & ctrl_in[gi];
    end
  endgenerate

  always_comb begin
    exe_cmd_clean = exe_cmd_in;
    if ((^exe_cmd_in) === 1'bx) begin
      exe_cmd_clean = 4'b0000;
    end
  end

  always_comb begin
    exe_cmd_next       = 4'b0000;
    pc_next            = '0;
    val_rn_next        = '0;
    val_rm_next        = '0;
    imm_next           = 1'b0;
    shift_operand_next = '0;
    signed_imm_24_next = '0;
    dest_next          = '0;
    src1_next          = '0;
    src2_next          = '0;
    sr_next            = '0;
    if (load_instr) begin
      exe_cmd_next       = exe_cmd_clean;
      pc_next            = pc_in;
      val_rn_next        = val_rn_in;
      val_rm_next        = val_rm_in;
      imm_next           = imm_in;
      shift_operand_next = shift_operand_in;
      signed_imm_24_next = signed_imm_24_in;
      dest_next          = dest_in;
      src1_next          = src1_in;
      src2_next          = src2_in;
      sr_next            = sr_in;
    end
  end

  always_comb begin
    bubble_cnt_next = bubble_cnt_reg;
    if (load_bubble && (bubble_cnt_reg != {CNT_W{1'b1}})) begin
      bubble_cnt_next = bubble_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_reg          <= '0;
      exe_cmd_reg       <= 4'b0000;
      pc_reg            <= '0;
      val_rn_reg        <= '0;
      val_rm_reg        <= '0;
      imm_reg           <= 1'b0;
      shift_operand_reg <= '0;
      signed_imm_24_reg <= '0;
      dest_reg          <= '0;
      src1_reg          <= '0;
      src2_reg          <= '0;
      sr_reg            <= '0;
      bubble_cnt_reg    <= '0;
    end else if (!hold) begin
      ctrl_reg          <= ctrl_next;
      exe_cmd_reg       <= exe_cmd_next;
      pc_reg            <= pc_next;
      val_rn_reg        <= val_rn_next;
      val_rm_reg        <= val_rm_next;
      imm_reg           <= imm_next;
      shift_operand_reg <= shift_operand_next;
      signed_imm_24_reg <= signed_imm_24_next;
      dest_reg          <= dest_next;
      src1_reg          <= src1_next;
      src2_reg          <= src2_next;
      sr_reg            <= sr_next;
      bubble_cnt_reg    <= bubble_cnt_next;
    end
  end

  assign {valid_out, mem_read_out, mem_write_out, wb_en_out, b_out, s_out} = ctrl_reg;
  assign exe_cmd_out       = exe_cmd_reg;
  assign pc_out            = pc_reg;
  assign val_rn_out        = val_rn_reg;
  assign val_rm_out        = val_rm_reg;
  assign imm_out           = imm_reg;
  assign shift_operand_out = shift_operand_reg;
  assign signed_imm_24_out = signed_imm_24_reg;
  assign dest_out          = dest_reg;
  assign src1_out          = src1_reg;
  assign src2_out          = src2_reg;
  assign sr_out            = sr_reg;
  assign bubble_cnt        = bubble_cnt_reg;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed vector table, randomized run against a
// rule-level model, and a bubble-counter saturation sequence.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        rst_n, freeze, flush, valid, mr, mw, wb, b, s;
    logic [3:0]  exe;
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] si;
    logic [3:0]  dest, src1, src2, sr;
  } in_t;

  typedef struct packed {
    logic        valid, mr, mw, wb, b, s;
    logic [3:0]  exe;
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] si;
    logic [3:0]  dest, src1, src2, sr;
    logic [15:0] cnt;
  } out_t;

  typedef struct {
    string name;
    in_t   stim;
    out_t  exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, freeze, flush, valid_in;
  logic        mem_read_in, mem_write_in, wb_en_in, b_in, s_in;
  logic [3:0]  exe_cmd_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic        imm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  dest_in, src1_in, src2_in, sr_in;
  logic        valid_out, mem_read_out, mem_write_out, wb_en_out, b_out, s_out;
  logic [3:0]  exe_cmd_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic        imm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;
  logic [3:0]  dest_out, src1_out, src2_out, sr_out;
  logic [15:0] bubble_cnt;
  out_t        act;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  id_ex_stage_reg #(.WORD_W(32), .REG_ADDR_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .wb_en_in(wb_en_in),
    .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in), .pc_in(pc_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .sr_in(sr_in),
    .valid_out(valid_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .wb_en_out(wb_en_out), .b_out(b_out), .s_out(s_out), .exe_cmd_out(exe_cmd_out),
    .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .imm_out(imm_out),
    .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .sr_out(sr_out),
    .bubble_cnt(bubble_cnt)
  );

  assign act = {valid_out, mem_read_out, mem_write_out, wb_en_out, b_out, s_out,
                exe_cmd_out, pc_out, val_rn_out, val_rm_out, imm_out,
                shift_operand_out, signed_imm_24_out, dest_out, src1_out, src2_out,
                sr_out, bubble_cnt};

  task automatic drive(input in_t i);
    rst_n = i.rst_n; freeze = i.freeze; flush = i.flush; valid_in = i.valid;
    mem_read_in = i.mr; mem_write_in = i.mw; wb_en_in = i.wb; b_in = i.b; s_in = i.s;
    exe_cmd_in = i.exe; pc_in = i.pc; val_rn_in = i.rn; val_rm_in = i.rm;
    imm_in = i.imm; shift_operand_in = i.sh; signed_imm_24_in = i.si;
    dest_in = i.dest; src1_in = i.src1; src2_in = i.src2; sr_in = i.sr;
  endtask

  task automatic check(input string name, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic apply(input string name, input in_t i, input out_t exp);
    @(negedge clk);
    drive(i);
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  // What a real instruction looks like once captured; unknown ALU commands become 0
  function automatic out_t as_loaded(input in_t i, input logic [15:0] cnt);
    out_t o;
    o.valid = 1'b1; o.mr = i.mr; o.mw = i.mw; o.wb = i.wb; o.b = i.b; o.s = i.s;
    o.exe = $isunknown(i.exe) ? 4'b0000 : i.exe;
    o.pc = i.pc; o.rn = i.rn; o.rm = i.rm; o.imm = i.imm; o.sh = i.sh; o.si = i.si;
    o.dest = i.dest; o.src1 = i.src1; o.src2 = i.src2; o.sr = i.sr; o.cnt = cnt;
    return o;
  endfunction

  function automatic void add(input string n, input in_t s, input out_t e);
    vec_t v;
    v.name = n; v.stim = s; v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic in_t rand_in();
    in_t i;
    i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    i.rst_n  = ($urandom_range(0, 19) != 0);
    i.freeze = ($urandom_range(0, 3) == 0);
    i.flush  = ($urandom_range(0, 7) == 0);
    i.valid  = ($urandom_range(0, 3) != 0);
    return i;
  endfunction

  initial begin
    in_t  z, s, add_i;
    out_t e, mdl;
    logic [15:0] c;

    drive('0);
    z = '0;
    z.rst_n = 1'b1;

    // reset with every input high
    s = '1; s.rst_n = 1'b0; e = '0;
    add("reset_c0", s, e);
    add("reset_c1", s, e);

    // LDR-style load
    s = z; s.valid = 1; s.exe = 4'b0010; s.mr = 1; s.wb = 1; s.dest = 4'd5;
    s.pc = 32'h0000_0104; s.rn = 32'h11; s.rm = 32'h22;
    e = '0; e.valid = 1; e.exe = 4'b0010; e.mr = 1; e.wb = 1; e.dest = 4'd5;
    e.pc = 32'h0000_0104; e.rn = 32'h11; e.rm = 32'h22;
    add("ldr_load", s, e);

    // ADD, then three frozen cycles with unrelated inputs
    add_i = z; add_i.valid = 1; add_i.exe = 4'b0100; add_i.wb = 1; add_i.dest = 4'd3;
    add_i.src1 = 4'd1; add_i.src2 = 4'd2; add_i.pc = 32'h108; add_i.rn = 32'd5;
    add_i.rm = 32'd7; add_i.sr = 4'b0010; add_i.sh = 12'h0a5;
    e = as_loaded(add_i, 16'd0);
    add("add_load", add_i, e);
    for (int k = 0; k < 3; k++) begin
      s = '1; s.flush = 0; s.pc = 32'(k); s.exe = 4'(k + 9);
      add("freeze_hold", s, e);
    end

    // STR arriving while frozen and flushed
    s = z; s.freeze = 1; s.flush = 1; s.valid = 1; s.mw = 1; s.exe = 4'b0100;
    s.dest = 4'd7; s.pc = 32'h10c;
    e = '0; e.cnt = 16'd1;
    add("flush_freeze_str", s, e);

    // branch with an undefined ALU command
    s = z; s.valid = 1; s.b = 1; s.exe = 4'bxxxx; s.si = 24'h123456; s.pc = 32'h110;
    e = '0; e.valid = 1; e.b = 1; e.exe = 4'b0000; e.si = 24'h123456; e.pc = 32'h110;
    e.cnt = 16'd1;
    add("branch_x_cmd", s, e);

    // empty decode slot is a bubble even with control bits high
    s = z; s.valid = 0; s.mr = 1; s.wb = 1; s.s = 1; s.pc = 32'hdead;
    e = '0; e.cnt = 16'd2;
    add("empty_slot", s, e);

    s = z; s.valid = 1; s.wb = 1; s.s = 1; s.dest = 4'd9; s.rn = 32'hcafe;
    e = '0; e.valid = 1; e.wb = 1; e.s = 1; e.dest = 4'd9; e.rn = 32'hcafe; e.cnt = 16'd2;
    add("load_again", s, e);

    s.freeze = 1; s.rst_n = 0;
    e = '0;
    add("reset_in_freeze", s, e);

    foreach (vecs[n]) apply(vecs[n].name, vecs[n].stim, vecs[n].exp);

    // randomized run against the rule-level model
    s = z; s.rst_n = 0;
    mdl = '0;
    apply("rand_reset", s, mdl);
    for (int n = 0; n < 400; n++) begin
      s = rand_in();
      if (!s.rst_n) begin
        mdl = '0;
      end else if (s.flush || (!s.freeze && !s.valid)) begin
        c = mdl.cnt;
        mdl = '0;
        mdl.cnt = (c == 16'hFFFF) ? c : c + 16'd1;
      end else if (!s.freeze) begin
        mdl = as_loaded(s, mdl.cnt);
      end
      apply("rand", s, mdl);
    end

    // counter saturation: bring it to FFFE, then 3 more flushes
    s = z; s.rst_n = 0;
    apply("sat_reset", s, '0);
    @(negedge clk);
    s = z; s.flush = 1;
    drive(s);
    repeat (65534) @(posedge clk);
    #1;
    e = '0; e.cnt = 16'hFFFE;
    check("sat_preload", e);
    e.cnt = 16'hFFFF;
    for (int k = 0; k < 3; k++) apply("sat_flush", s, e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
